// File: rtl/branch_target_buffer_if.sv
// Fetch/resolve bus between the pipeline and the branch target buffer.
// The pipeline drives lookups and EX resolutions; the BTB returns predictions and recovery info.
interface branch_target_buffer_if #(
  parameter int CNT_WIDTH = 16
);
  logic [31:0]          lookupPC;
  logic                 predTaken;
  logic [31:0]          predTarget;
  logic                 updValid;
  logic [31:0]          updPC;
  logic                 updTaken;
  logic [31:0]          updTarget;
  logic                 updPredTaken;
  logic [31:0]          updPredTarget;
  logic                 invalidate;
  logic                 mispredict;
  logic [31:0]          recoverPC;
  logic [CNT_WIDTH-1:0] mispredictCount;

  modport master (
    output lookupPC, updValid, updPC, updTaken, updTarget,
           updPredTaken, updPredTarget, invalidate,
    input  predTaken, predTarget, mispredict, recoverPC, mispredictCount
  );

  modport slave (
    input  lookupPC, updValid, updPC, updTaken, updTarget,
           updPredTaken, updPredTarget, invalidate,
    output predTaken, predTarget, mispredict, recoverPC, mispredictCount
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters, combinational IF lookup,
// EX-side training, misprediction detection and a saturating mispredict counter.
module branch_target_buffer #(
  parameter int ENTRIES   = 16,
  parameter int CNT_WIDTH = 16
) (
  input logic                    clk,
  input logic                    reset,
  branch_target_buffer_if.slave  btb
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [TAGW-1:0]      tag_q    [ENTRIES];
  logic [TAGW-1:0]      tag_d    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];
  logic [31:0]          target_d [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];
  logic [1:0]           ctr_d    [ENTRIES];
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  logic [IDX-1:0]  lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit, lk_taken, mispredict;

  // Lookup
  assign lk_idx   = btb.lookupPC[IDX+1:2];
  assign lk_tag   = btb.lookupPC[31:IDX+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = !reset && lk_hit && ctr_q[lk_idx][1];

  assign btb.predTaken  = lk_taken;
  assign btb.predTarget = lk_taken ? target_q[lk_idx] : btb.lookupPC + 32'd4;

  // Resolution checks use only what was carried down the pipe, never the table.
  assign mispredict = btb.updValid &&
                      ((btb.updPredTaken != btb.updTaken) ||
                       (btb.updTaken && (btb.updPredTarget != btb.updTarget)));

  assign btb.mispredict      = mispredict;
  assign btb.recoverPC       = btb.updTaken ? btb.updTarget : btb.updPC + 32'd4;
  assign btb.mispredictCount = mcnt_q;

  assign up_idx = btb.updPC[IDX+1:2];
  assign up_tag = btb.updPC[31:IDX+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (btb.updValid) begin
      if (up_hit) begin
        if (btb.updTaken) begin
          ctr_d[up_idx]    = (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
          target_d[up_idx] = btb.updTarget;
        end else begin
          ctr_d[up_idx] = (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
        end
      end else if (btb.updTaken) begin
        // New entries start weakly taken so one not-taken flips them.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = btb.updTarget;
        ctr_d[up_idx]    = 2'd2;
      end
    end
    if (btb.invalidate) begin
      valid_d = '0;
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    if (mispredict && (mcnt_q != {CNT_WIDTH{1'b1}})) begin
      mcnt_d = mcnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      mcnt_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      mcnt_q   <= mcnt_d;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: a 16-entry and a 32-entry instance
// fed the same resolve stream, checked against hand-computed values.
module tb_branch_target_buffer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   exp_cnt;

  branch_target_buffer_if #(.CNT_WIDTH(4)) bus ();
  branch_target_buffer_if #(.CNT_WIDTH(4)) bus32 ();

  branch_target_buffer #(.ENTRIES(16), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .btb(bus.slave)
  );
  branch_target_buffer #(.ENTRIES(32), .CNT_WIDTH(4)) dut32 (
    .clk(clk), .reset(reset), .btb(bus32.slave)
  );

  assign bus32.lookupPC      = bus.lookupPC;
  assign bus32.updValid      = bus.updValid;
  assign bus32.updPC         = bus.updPC;
  assign bus32.updTaken      = bus.updTaken;
  assign bus32.updTarget     = bus.updTarget;
  assign bus32.updPredTaken  = bus.updPredTaken;
  assign bus32.updPredTarget = bus.updPredTarget;
  assign bus32.invalidate    = bus.invalidate;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic etk, input logic [31:0] etg);
    bus.lookupPC = pc;
    #1;
    check_val("predTaken", {31'd0, bus.predTaken}, {31'd0, etk});
    check_val("predTarget", bus.predTarget, etg);
  endtask

  task automatic look32(input logic [31:0] pc, input logic etk, input logic [31:0] etg);
    bus.lookupPC = pc;
    #1;
    check_val("predTaken32", {31'd0, bus32.predTaken}, {31'd0, etk});
    check_val("predTarget32", bus32.predTarget, etg);
  endtask

  // One resolve cycle; exp_mp and the recovery PC are worked out by hand per call.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic ptk, input logic [31:0] ptg, input logic exp_mp,
                     input logic [31:0] exp_rec, input logic inv);
    bus.updPC         = pc;
    bus.updTaken      = tk;
    bus.updTarget     = tg;
    bus.updPredTaken  = ptk;
    bus.updPredTarget = ptg;
    bus.invalidate    = inv;
    bus.updValid      = 1'b1;
    #1;
    check_val("mispredict", {31'd0, bus.mispredict}, {31'd0, exp_mp});
    check_val("mispredict32", {31'd0, bus32.mispredict}, {31'd0, exp_mp});
    check_val("recoverPC", bus.recoverPC, exp_rec);
    if (exp_mp && exp_cnt != 15) exp_cnt++;
    @(posedge clk);
    #1;
    bus.updValid   = 1'b0;
    bus.invalidate = 1'b0;
    #1;
    check_val("mispredictCount", {28'd0, bus.mispredictCount}, exp_cnt);
    check_val("mispredictCount32", {28'd0, bus32.mispredictCount}, exp_cnt);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_cnt = 0;
    reset = 1'b1;
    bus.lookupPC = 32'h0040_0010;
    bus.updValid = 1'b0;
    bus.updPC = '0;
    bus.updTaken = 1'b0;
    bus.updTarget = '0;
    bus.updPredTaken = 1'b0;
    bus.updPredTarget = '0;
    bus.invalidate = 1'b0;
    #12;
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    check_val("count_reset", {28'd0, bus.mispredictCount}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Allocation; same-cycle lookup must still see the old (empty) entry.
    bus.lookupPC      = 32'h0040_0010;
    bus.updPC         = 32'h0040_0010;
    bus.updTaken      = 1'b1;
    bus.updTarget     = 32'h0040_0040;
    bus.updPredTaken  = 1'b0;
    bus.updPredTarget = 32'h0040_0014;
    bus.updValid      = 1'b1;
    #1;
    check_val("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check_val("alloc_recoverPC", bus.recoverPC, 32'h0040_0040);
    check_val("same_cycle_old", {31'd0, bus.predTaken}, 32'd0);
    @(posedge clk);
    #1;
    bus.updValid = 1'b0;
    exp_cnt = 1;
    look(32'h0040_0010, 1'b1, 32'h0040_0040);
    check_val("alloc_count", {28'd0, bus.mispredictCount}, 32'd1);

    // Counter hysteresis on 0x00400010
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0014, 1'b0); // ctr 1
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014, 1'b0); // ctr 0
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0040, 1'b0); // ctr 1
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014, 1'b1, 32'h0040_0040, 1'b0); // ctr 2
    look(32'h0040_0010, 1'b1, 32'h0040_0040);
    upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040, 1'b0); // ctr 3
    upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0040, 1'b0); // ctr 3 held
    look(32'h0040_0010, 1'b1, 32'h0040_0040);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0014, 1'b0); // ctr 2
    look(32'h0040_0010, 1'b1, 32'h0040_0040);
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0014, 1'b0); // ctr 1
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    // Right direction, wrong target still mispredicts; target is overwritten.
    upd(32'h0040_0010, 1'b1, 32'h0040_0080, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0080, 1'b0); // ctr 2
    look(32'h0040_0010, 1'b1, 32'h0040_0080);

    // Alias replacement at index 4 (16 entries), distinct index 20 with 32 entries
    upd(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054, 1'b1, 32'h0040_0100, 1'b0);
    look(32'h0040_0050, 1'b1, 32'h0040_0100);
    look(32'h0040_0010, 1'b0, 32'h0040_0014);
    look32(32'h0040_0010, 1'b1, 32'h0040_0080);
    look32(32'h0040_0050, 1'b1, 32'h0040_0100);
    // Not-taken miss does not allocate or disturb the index
    upd(32'h0040_0090, 1'b0, 32'h0, 1'b0, 32'h0040_0094, 1'b0, 32'h0040_0094, 1'b0);
    look(32'h0040_0050, 1'b1, 32'h0040_0100);
    look(32'h0040_0090, 1'b0, 32'h0040_0094);

    // Invalidate wins over a same-cycle allocation
    upd(32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0024, 1'b1, 32'h0040_0200, 1'b1);
    look(32'h0040_0020, 1'b0, 32'h0040_0024);
    look(32'h0040_0050, 1'b0, 32'h0040_0054);
    look32(32'h0040_0010, 1'b0, 32'h0040_0014);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      upd(32'h0040_0030, 1'b0, 32'h0, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0034, 1'b0);
    end
    check_val("count_sat", {28'd0, bus.mispredictCount}, 32'd15);
    upd(32'h0040_0060, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0300, 1'b0);
    look(32'h0040_0060, 1'b1, 32'h0040_0300);
    check_val("count_held", {28'd0, bus.mispredictCount}, 32'd15);

    // Asynchronous reset between edges
    @(negedge clk);
    reset = 1'b1;
    #1;
    look(32'h0040_0060, 1'b0, 32'h0040_0064);
    check_val("count_async_rst", {28'd0, bus.mispredictCount}, 32'd0);
    check_val("count_async_rst32", {28'd0, bus32.mispredictCount}, 32'd0);
    bus.updPC         = 32'h0040_0060;
    bus.updTaken      = 1'b1;
    bus.updTarget     = 32'h0040_0400;
    bus.updPredTaken  = 1'b0;
    bus.updPredTarget = 32'h0040_0064;
    bus.updValid      = 1'b1;
    #1;
    check_val("rst_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check_val("rst_recoverPC", bus.recoverPC, 32'h0040_0400);
    @(posedge clk);
    #1;
    bus.updValid = 1'b0;
    check_val("rst_count_ignored", {28'd0, bus.mispredictCount}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    look(32'h0040_0060, 1'b0, 32'h0040_0064);
    check_val("post_rst_count", {28'd0, bus.mispredictCount}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It is looked up combinationally in IF with the current fetch PC and supplies a predicted next PC. It is trained from EX when branches and jumps resolve. It detects mispredictions against the prediction carried down the pipe, drives the recovery PC, and keeps a saturating mispredict counter. This replaces the fixed predict-not-taken/flush-in-EX scheme with dynamic prediction.

## Interface
Parameters:
- ENTRIES, 16, number of entries; power of two, at least 2. IDX = log2(ENTRIES).
- CNT_WIDTH, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- lookupPC  in  32  IF fetch PC.
- predTaken  out  1  predicted taken (combinational).
- predTarget  out  32  predicted next PC (combinational).
- updValid  in  1  an EX branch/jump resolves this cycle.
- updPC  in  32  PC of the resolving instruction.
- updTaken  in  1  actual outcome.
- updTarget  in  32  actual target when taken.
- updPredTaken  in  1  prediction made for it in IF.
- updPredTarget  in  32  predicted next PC made for it in IF.
- invalidate  in  1  synchronous clear of all valid bits.
- mispredict  out  1  combinational; redirect and flush IF/ID.
- recoverPC  out  32  combinational correct next PC.
- mispredictCount  out  CNT_WIDTH  saturating mispredict count.

Reset: clock domain clk, asynchronous active-high reset named reset.

## Operation
- Entry fields: valid, tag = pc[31:IDX+2], target[31:0], ctr[1:0]. Index = pc[IDX+1:2]; pc[1:0] is ignored.
- Lookup: hit = valid[idx] && tag match.
  - If hit && ctr[1]: predTaken=1 and predTarget=target.
  - Otherwise: predTaken=0 and predTarget=lookupPC+4 (mod 2^32).
- Update on posedge when updValid=1 and invalidate=0:
  - Hit, taken: ctr increments, saturating at 3; target is overwritten with updTarget.
  - Hit, not taken: ctr decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate or replace the entry. Set valid=1, write tag and target, and set ctr=2 (weakly taken).
  - Miss, not taken: no change. There is no allocation.
- mispredict = updValid && ((updPredTaken != updTaken) || (updTaken && updPredTarget != updTarget)). It does not depend on the current table contents.
- recoverPC = updTaken ? updTarget : updPC+4. It is valid whenever updValid=1 and is don't-care otherwise.
- mispredictCount increments on each posedge where mispredict=1. It holds at all-ones. It is cleared only by reset.
- invalidate=1 clears every valid bit at posedge. It wins over a same-cycle update: no entry is valid afterwards. mispredictCount still counts that cycle's mispredict.

## Timing
- Lookup path is combinational, with zero latency from lookupPC to predTaken/predTarget.
- Update is visible to lookups from the cycle after the posedge that writes it.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents.
- Reset asserts asynchronously. While reset is high:
  - all valid bits are 0, ctr=0, target=0, tag=0, and mispredictCount=0;
  - predTaken=0 and predTarget=lookupPC+4 immediately;
  - updates are ignored.
- mispredict and recoverPC are combinational from the upd* inputs. They are not gated by reset.
- Deassertion of reset is synchronous to clk externally. The first update is taken on the first posedge with reset low.

## Test plan
All scenarios use ENTRIES=16 (index pc[5:2], tag pc[31:6]) and CNT_WIDTH=4.
1. Reset: after reset, lookupPC=0x00400010 -> predTaken=0, predTarget=0x00400014, mispredictCount=0.
2. Allocation and detection: updValid with updPC=0x00400010, updTaken=1, updTarget=0x00400040, updPredTaken=0.
   - Same cycle: mispredict=1, recoverPC=0x00400040.
   - Next cycle: lookup 0x00400010 gives predTaken=1, predTarget=0x00400040; mispredictCount=1.
3. Counter hysteresis: starting from step 2, drive two not-taken updates on 0x00400010.
   - After the first: predTaken=0 (ctr=1).
   - After the second: ctr=0.
   - Then three taken updates: predTaken=1 after the second (ctr=2), and ctr saturates at 3.
   - A not-taken update with updPredTaken=0 gives mispredict=0.
4. Alias replacement: with 0x00400010 valid, do a taken update on 0x00400050 (same index 4) with target 0x00400100.
   - Lookup 0x00400050 -> taken, 0x00400100.
   - Lookup 0x00400010 -> miss, 0x00400014.
   - Updating the same index with ENTRIES=32 and 0x00400050 lands at index 20 and no aliasing occurs.
5. Simultaneous events:
   - invalidate=1 together with a taken update on 0x00400020 -> next cycle every lookup misses, including 0x00400020.
   - Lookup of an index in the same cycle as its update returns the old value.
6. Saturation and async reset:
   - 20 consecutive mispredicting updates -> mispredictCount=15, held.
   - Assert reset mid-cycle between edges -> mispredictCount=0 and predTaken=0 without waiting for a clk edge.
